idma_mc_port: RTL and testbench

// Multi-channel host (IDMA) port. Gives an external host access to PM/DM through NCH independent

---
 rtl/idma_mc_port_if.sv | 16 +
 rtl/idma_mc_port.sv | 217 +++++++++++++++++++++
 tb/tb_idma_mc_port.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/idma_mc_port_if.sv
// Host IDMA bus (select/latch/strobes/data/ack) shared between the host and the multi-channel port.
interface idma_mc_port_if #(parameter int HW = 16);
  logic          X_ISn;
  logic          X_IAL;
  logic          X_IRDn;
  logic          X_IWRn;
  logic [HW-1:0] T_IAD;
  logic [HW-1:0] IAD_do;
  logic          IAD_oe;
  logic          IACKn;

  modport master (output X_ISn, X_IAL, X_IRDn, X_IWRn, T_IAD,
                  input  IAD_do, IAD_oe, IACKn);
  modport slave  (input  X_ISn, X_IAL, X_IRDn, X_IWRn, T_IAD,
                  output IAD_do, IAD_oe, IACKn);
endinterface

// File: rtl/idma_mc_port.sv
// Multi-channel IDMA host port: per-channel address/space/word-count, PM two-phase access, DONE pulses.
// Optional boot-hold flag enabled by defining IDMA_MC_BOOT_EN.
module idma_mc_port #(
  parameter int HW  = 16,
  parameter int AW  = 14,
  parameter int NCH = 4,
  parameter int WCW = 3,
  parameter int PMW = 24
) (
  input  logic           DSPCLK,
  input  logic           RST,
  idma_mc_port_if.slave  host,
  input  logic [WCW-1:0] RWAIT,
  input  logic [WCW-1:0] WWAIT,
  output logic           DSreq,
  input  logic           DSack,
  output logic [AW-1:0]  MEM_addr,
  output logic           MEM_pm,
  output logic           MEM_we,
  output logic [PMW-1:0] MEM_wd,
  input  logic [PMW-1:0] MEM_rd,
  output logic [NCH-1:0] DONE,
  input  logic           X_BMODE,
  output logic           BOOT
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PB  = PMW - HW;

  // state     | meaning
  // S_IDLE    | waiting for latch / read / write begin, IACKn low
  // S_RD_REQ  | DM or PM 1st-phase read, DSreq held until DSack
  // S_RD_WAIT | PM 2nd-phase read, RWAIT countdown
  // S_WR_WAIT | write, WWAIT countdown before IAD capture
  // S_WR_REQ  | DM or PM 2nd-phase write, DSreq held until DSack
  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_WAIT, S_WR_REQ} state_t;
  state_t state;

  logic          isn_r, ial_r, irdn_r, iwrn_r;
  logic [HW-1:0] iad_r;
  logic          rdcmd_d, wrcmd_d;
  logic          iackn, pm_ph, arm;
  logic [CHW-1:0] ach;
  logic [HW-1:0] iad_do;
  logic [WCW-1:0] wcnt;
  logic [PB-1:0] rbuf;
  logic [HW-1:0] wbuf;
  logic [AW-1:0] addr  [NCH];
  logic          space [NCH];
  logic [HW-1:0] count [NCH];

  logic rdcmd, wrcmd, rdbeg, wrbeg, latch, pm_cur, word_done, boot_clr;

  assign rdcmd = ~isn_r & ~irdn_r;
  assign wrcmd = ~isn_r & ~iwrn_r;
  assign rdbeg = rdcmd & ~rdcmd_d;
  assign wrbeg = wrcmd & ~wrcmd_d;
  assign latch = ial_r & ~isn_r & ~iackn;
  assign pm_cur = space[ach];

  assign MEM_addr    = addr[ach];
  assign MEM_pm      = pm_cur;
  assign host.IACKn  = iackn;
  assign host.IAD_do = iad_do;
  assign host.IAD_oe = rdcmd | (state == S_RD_REQ) | (state == S_RD_WAIT);

  // DM words finish on DSack; PM words finish on their 2nd phase
  assign word_done = ((state == S_RD_REQ) & DSack & ~pm_cur) |
                     ((state == S_RD_WAIT) & (wcnt == '0)) |
                     ((state == S_WR_REQ) & DSack);
  assign boot_clr  = (state == S_WR_REQ) & DSack & pm_cur & (ach == '0) &
                     (&addr[0]) & (count[0] == HW'(1));

  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST) begin
      isn_r   <= 1'b1;
      ial_r   <= 1'b0;
      irdn_r  <= 1'b1;
      iwrn_r  <= 1'b1;
      iad_r   <= '0;
      rdcmd_d <= 1'b0;
      wrcmd_d <= 1'b0;
      state   <= S_IDLE;
      iackn   <= 1'b0;
      DSreq   <= 1'b0;
      MEM_we  <= 1'b0;
      MEM_wd  <= '0;
      iad_do  <= '0;
      DONE    <= '0;
      pm_ph   <= 1'b0;
      arm     <= 1'b0;
      ach     <= '0;
      wcnt    <= '0;
      rbuf    <= '0;
      wbuf    <= '0;
      for (int i = 0; i < NCH; i++) begin
        addr[i]  <= '0;
        space[i] <= 1'b0;
        count[i] <= '0;
      end
    end else begin
      isn_r   <= host.X_ISn;
      ial_r   <= host.X_IAL;
      irdn_r  <= host.X_IRDn;
      iwrn_r  <= host.X_IWRn;
      iad_r   <= host.T_IAD;
      rdcmd_d <= rdcmd;
      wrcmd_d <= wrcmd;
      DONE    <= '0;
      case (state)
        S_IDLE: begin
          if (rdbeg) begin
            iackn <= 1'b1;
            if (pm_cur && pm_ph) begin
              wcnt  <= RWAIT;
              state <= S_RD_WAIT;
            end else begin
              DSreq <= 1'b1;
              state <= S_RD_REQ;
            end
          end else if (wrbeg) begin
            iackn <= 1'b1;
            wcnt  <= WWAIT;
            state <= S_WR_WAIT;
          end else if (latch) begin
            if (iad_r[HW-1]) begin
              ach <= iad_r[CHW-1:0];
              if (iad_r[8]) arm <= 1'b1;
            end else begin
              addr[ach]  <= iad_r[AW-1:0];
              space[ach] <= iad_r[AW];
              pm_ph      <= 1'b0;
            end
          end
        end
        S_RD_REQ: begin
          if (DSack) begin
            DSreq <= 1'b0;
            iackn <= 1'b0;
            state <= S_IDLE;
            if (pm_cur) begin
              iad_do <= MEM_rd[PMW-1:PB];
              rbuf   <= MEM_rd[PB-1:0];
              pm_ph  <= 1'b1;
            end else begin
              iad_do <= MEM_rd[HW-1:0];
            end
          end
        end
        S_RD_WAIT: begin
          if (wcnt == '0) begin
            iad_do <= HW'(rbuf);
            iackn  <= 1'b0;
            state  <= S_IDLE;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_WR_WAIT: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else if (arm) begin
            count[ach] <= iad_r;
            arm        <= 1'b0;
            iackn      <= 1'b0;
            state      <= S_IDLE;
          end else if (!pm_cur) begin
            MEM_wd <= PMW'(iad_r);
            MEM_we <= 1'b1;
            DSreq  <= 1'b1;
            state  <= S_WR_REQ;
          end else if (!pm_ph) begin
            wbuf  <= iad_r;
            pm_ph <= 1'b1;
            iackn <= 1'b0;
            state <= S_IDLE;
          end else begin
            MEM_wd <= {wbuf, iad_r[PB-1:0]};
            MEM_we <= 1'b1;
            DSreq  <= 1'b1;
            state  <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (DSack) begin
            DSreq  <= 1'b0;
            MEM_we <= 1'b0;
            iackn  <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // zero count means unlimited: no decrement, no pulse
      if (word_done) begin
        addr[ach] <= addr[ach] + 1'b1;
        pm_ph     <= 1'b0;
        if (count[ach] != '0) begin
          count[ach] <= count[ach] - 1'b1;
          if (count[ach] == HW'(1)) DONE[ach] <= 1'b1;
        end
      end
    end
  end

`ifdef IDMA_MC_BOOT_EN
  logic boot_r;
  always_ff @(posedge DSPCLK) begin
    if (RST)           boot_r <= X_BMODE;
    else if (boot_clr) boot_r <= 1'b0;
  end
  assign BOOT = boot_r;
`else
  logic unused_boot;
  assign unused_boot = X_BMODE ^ boot_clr;
  assign BOOT = 1'b0;
`endif
endmodule

// File: tb/tb_idma_mc_port.sv
// Directed bench for idma_mc_port: DM/PM access, channel select, word counts, wrap, reset, boot flag.
module tb_idma_mc_port;
  logic        DSPCLK = 1'b0;
  logic        RST;
  logic [2:0]  RWAIT, WWAIT;
  logic        DSreq, DSack, MEM_pm, MEM_we, X_BMODE, BOOT;
  logic [13:0] MEM_addr;
  logic [23:0] MEM_wd, MEM_rd;
  logic [3:0]  DONE;

  idma_mc_port_if #(.HW(16)) bus ();

  idma_mc_port dut (
    .DSPCLK(DSPCLK), .RST(RST), .host(bus.slave),
    .RWAIT(RWAIT), .WWAIT(WWAIT),
    .DSreq(DSreq), .DSack(DSack),
    .MEM_addr(MEM_addr), .MEM_pm(MEM_pm), .MEM_we(MEM_we),
    .MEM_wd(MEM_wd), .MEM_rd(MEM_rd),
    .DONE(DONE), .X_BMODE(X_BMODE), .BOOT(BOOT)
  );

  always #5 DSPCLK = ~DSPCLK;

  logic [23:0] pmm [0:16383];
  logic [23:0] dmm [0:16383];
  assign MEM_rd = MEM_pm ? pmm[MEM_addr] : dmm[MEM_addr];

  int checks = 0;
  int failures = 0;

  int          nreq, done_cnt;
  logic [13:0] rq_addr;
  logic        rq_pm, rq_we, oe_seen;
  logic [23:0] rq_wd;
  logic [3:0]  done_or;
  logic [15:0] rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample_bus();
    if (DONE != 4'b0) begin
      done_cnt++;
      done_or = done_or | DONE;
    end
    oe_seen = oe_seen | bus.IAD_oe;
    if (DSack) begin
      DSack = 1'b0;
    end else if (DSreq) begin
      nreq++;
      rq_addr = MEM_addr;
      rq_pm   = MEM_pm;
      rq_we   = MEM_we;
      rq_wd   = MEM_wd;
      if (MEM_we) begin
        if (MEM_pm) pmm[MEM_addr] = MEM_wd;
        else        dmm[MEM_addr] = MEM_wd;
      end
      DSack = 1'b1;
    end
  endtask

  task automatic host_latch(input logic [15:0] v);
    @(negedge DSPCLK);
    bus.X_ISn = 1'b0; bus.X_IAL = 1'b1; bus.T_IAD = v;
    @(negedge DSPCLK);
    bus.X_IAL = 1'b0; bus.X_ISn = 1'b1;
    repeat (2) @(negedge DSPCLK);
  endtask

  task automatic host_cycle(input bit rd, input logic [15:0] wdata);
    int t;
    nreq = 0; done_cnt = 0; done_or = 4'b0; oe_seen = 1'b0;
    rq_addr = '0; rq_pm = 1'b0; rq_we = 1'b0; rq_wd = '0;
    @(negedge DSPCLK);
    bus.X_ISn = 1'b0; bus.T_IAD = wdata;
    if (rd) bus.X_IRDn = 1'b0; else bus.X_IWRn = 1'b0;
    t = 0;
    do begin @(negedge DSPCLK); sample_bus(); t++; end while (!bus.IACKn && t < 10);
    check("iackn_rise", {31'b0, bus.IACKn}, 32'd1);
    t = 0;
    do begin @(negedge DSPCLK); sample_bus(); t++; end while (bus.IACKn && t < 100);
    check("iackn_fall", {31'b0, bus.IACKn}, 32'd0);
    rdata = bus.IAD_do;
    DSack = 1'b0;
    bus.X_ISn = 1'b1; bus.X_IRDn = 1'b1; bus.X_IWRn = 1'b1;
    repeat (2) begin @(negedge DSPCLK); sample_bus(); end
  endtask

  initial begin
    int t;
    for (int i = 0; i < 16384; i++) begin pmm[i] = '0; dmm[i] = '0; end
    bus.X_ISn = 1'b1; bus.X_IAL = 1'b0; bus.X_IRDn = 1'b1; bus.X_IWRn = 1'b1;
    bus.T_IAD = '0;
    RWAIT = 3'd1; WWAIT = 3'd2; DSack = 1'b0; X_BMODE = 1'b1;
    RST = 1'b1;
    repeat (3) @(negedge DSPCLK);
    RST = 1'b0;
    @(negedge DSPCLK);

    check("rst_iackn", {31'b0, bus.IACKn}, 32'd0);
    check("rst_dsreq", {31'b0, DSreq}, 32'd0);
    check("rst_we",    {31'b0, MEM_we}, 32'd0);
    check("rst_oe",    {31'b0, bus.IAD_oe}, 32'd0);
    check("rst_do",    {16'b0, bus.IAD_do}, 32'd0);
    check("rst_done",  {28'b0, DONE}, 32'd0);
    check("rst_addr",  {18'b0, MEM_addr}, 32'd0);
`ifdef IDMA_MC_BOOT_EN
    check("rst_boot",  {31'b0, BOOT}, 32'd1);
`else
    check("rst_boot",  {31'b0, BOOT}, 32'd0);
`endif

    // DM write on ch0, then ch0 advanced and ch1 untouched
    host_latch(16'h8000);
    host_latch(16'h0010);
    host_cycle(1'b0, 16'h1234);
    check("dmw_nreq", nreq, 1);
    check("dmw_addr", {18'b0, rq_addr}, 32'h0010);
    check("dmw_pm",   {31'b0, rq_pm}, 32'd0);
    check("dmw_we",   {31'b0, rq_we}, 32'd1);
    check("dmw_wd",   {8'b0, rq_wd}, 32'h001234);
    host_cycle(1'b1, 16'h0);
    check("dmr_addr_inc", {18'b0, rq_addr}, 32'h0011);
    check("dmr_oe", {31'b0, oe_seen}, 32'd1);
    host_latch(16'h8001);
    host_cycle(1'b1, 16'h0);
    check("ch1_addr", {18'b0, rq_addr}, 32'h0000);
    host_latch(16'h8000);
    host_latch(16'h0010);
    host_cycle(1'b1, 16'h0);
    check("dmr_data", {16'b0, rdata}, 32'h1234);

    // PM two-phase write then read back
    host_latch(16'h4100);
    host_cycle(1'b0, 16'hABCD);
    check("pmw1_nreq", nreq, 0);
    host_cycle(1'b0, 16'h0056);
    check("pmw2_nreq", nreq, 1);
    check("pmw2_addr", {18'b0, rq_addr}, 32'h0100);
    check("pmw2_pm",   {31'b0, rq_pm}, 32'd1);
    check("pmw2_wd",   {8'b0, rq_wd}, 32'hABCD56);
    host_latch(16'h4100);
    host_cycle(1'b1, 16'h0);
    check("pmr1_nreq", nreq, 1);
    check("pmr1_data", {16'b0, rdata}, 32'hABCD);
    RWAIT = 3'd3;
    host_cycle(1'b1, 16'h0);
    check("pmr2_nreq", nreq, 0);
    check("pmr2_data", {16'b0, rdata}, 32'h0056);
    host_cycle(1'b1, 16'h0);
    check("pmr_next_addr", {18'b0, rq_addr}, 32'h0101);

    // word count on ch2
    host_latch(16'h8102);
    host_cycle(1'b0, 16'h0002);
    check("cnt_load_nreq", nreq, 0);
    host_latch(16'h0000);
    host_cycle(1'b0, 16'h1111);
    check("cnt_w1_done", done_cnt, 0);
    host_cycle(1'b0, 16'h2222);
    check("cnt_w2_done", done_cnt, 1);
    check("cnt_w2_mask", {28'b0, done_or}, 32'h4);
    host_cycle(1'b0, 16'h3333);
    check("cnt_w3_done", done_cnt, 0);
    check("cnt_w3_addr", {18'b0, rq_addr}, 32'h0002);

    // address wrap on ch0
    host_latch(16'h8000);
    host_latch(16'h3FFF);
    host_cycle(1'b1, 16'h0);
    check("wrap_addr0", {18'b0, rq_addr}, 32'h3FFF);
    host_cycle(1'b1, 16'h0);
    check("wrap_addr1", {18'b0, rq_addr}, 32'h0000);

    // reset while PM 2nd-phase write request is pending
    host_latch(16'h4005);
    host_cycle(1'b0, 16'h1111);
    @(negedge DSPCLK);
    bus.X_ISn = 1'b0; bus.X_IWRn = 1'b0; bus.T_IAD = 16'h2222;
    t = 0;
    do begin @(negedge DSPCLK); t++; end while (!DSreq && t < 20);
    check("mid_dsreq", {31'b0, DSreq}, 32'd1);
    #3 RST = 1'b1;
    #1;
    check("mid_rst_dsreq", {31'b0, DSreq}, 32'd0);
    check("mid_rst_iackn", {31'b0, bus.IACKn}, 32'd0);
    check("mid_rst_we",    {31'b0, MEM_we}, 32'd0);
    @(negedge DSPCLK);
    bus.X_ISn = 1'b1; bus.X_IWRn = 1'b1;
    @(negedge DSPCLK);
    RST = 1'b0;
    @(negedge DSPCLK);
    host_cycle(1'b1, 16'h0);
    check("post_rst_addr", {18'b0, rq_addr}, 32'h0000);
    check("post_rst_pm",   {31'b0, rq_pm}, 32'd0);
    host_latch(16'h4000);
    host_cycle(1'b0, 16'h0077);
    check("post_rst_pm1", nreq, 0);
    host_cycle(1'b0, 16'h0088);
    check("post_rst_pm2_addr", {18'b0, rq_addr}, 32'h0000);

    // boot-hold release on ch0 PM word wrapping to address 0 with count reaching 0
    host_latch(16'h8100);
    host_cycle(1'b0, 16'h0001);
    host_latch(16'h7FFF);
    host_cycle(1'b0, 16'h00AA);
`ifdef IDMA_MC_BOOT_EN
    check("boot_hold", {31'b0, BOOT}, 32'd1);
`else
    check("boot_hold", {31'b0, BOOT}, 32'd0);
`endif
    host_cycle(1'b0, 16'h00BB);
    check("boot_wd", {8'b0, rq_wd}, 32'h00AABB);
    check("boot_done", {28'b0, done_or}, 32'h1);
    check("boot_clear", {31'b0, BOOT}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
